// File: rtl/pixel_condition_pipe_if.sv
// rtl/pixel_condition_pipe_if.sv - pixel stream bus into and out of the conditioning pipe
interface pixel_condition_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 10,
    parameter int X_W   = 7,
    parameter int Y_W   = 6
) ();
    logic             in_valid;
    logic [IN_W-1:0]  din;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             dead_pix;
    logic             out_valid;
    logic [OUT_W-1:0] dout;
    logic [X_W-1:0]   out_x;
    logic [Y_W-1:0]   out_y;

    modport master (
        output in_valid, din, x, y, dead_pix,
        input  out_valid, dout, out_x, out_y
    );

    modport slave (
        input  in_valid, din, x, y, dead_pix,
        output out_valid, dout, out_x, out_y
    );
endinterface

// File: rtl/pixel_condition_pipe.sv
// rtl/pixel_condition_pipe.sv - 2-cycle clamp/scale, dead-pixel fill and test pattern pipe; DEAD_CNT_EN adds dead_count
module pixel_condition_pipe #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 10,
    parameter int SHIFT     = 1,
    parameter int SAT_TH    = 2045,
    parameter int SAT_VAL   = 1022,
    parameter int DEAD_FILL = 512,
    parameter int X_W       = 7,
    parameter int Y_W       = 6,
    parameter int MARK_X0   = 39,
    parameter int MARK_X1   = 40,
    parameter int MARK_Y0   = 31,
    parameter int MARK_Y1   = 32,
    parameter int MARK_MIN  = 250,
    parameter int MARK_MAX  = 1000,
    parameter int MARK_STEP = 50,
    parameter int TEST_BG   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_condition_pipe_if.slave bus,
    input  logic                 frame_start,
    input  logic                 test_req,
    output logic                 test_active,
    output logic [OUT_W-1:0]     marker_level
`ifdef DEAD_CNT_EN
    ,
    output logic [15:0]          dead_count
`endif
);

    if (OUT_W + SHIFT > IN_W) begin : g_bad_width
        $error("pixel_condition_pipe: OUT_W+SHIFT must not exceed IN_W");
    end
    if (IN_W > 31) begin : g_bad_in_w
        $error("pixel_condition_pipe: IN_W must be below 32");
    end
    if (SAT_VAL >= (1 << OUT_W) || DEAD_FILL >= (1 << OUT_W) || TEST_BG >= (1 << OUT_W)) begin : g_bad_const
        $error("pixel_condition_pipe: SAT_VAL/DEAD_FILL/TEST_BG do not fit OUT_W");
    end
    if (MARK_MIN >= (1 << OUT_W) || MARK_MAX >= (1 << OUT_W) || MARK_STEP >= (1 << OUT_W)
        || MARK_X0 >= (1 << OUT_W) || MARK_X1 >= (1 << OUT_W)
        || MARK_Y0 >= (1 << OUT_W) || MARK_Y1 >= (1 << OUT_W)) begin : g_bad_mark
        $error("pixel_condition_pipe: MARK_* constants do not fit OUT_W");
    end

    localparam logic [31:0]      SAT_TH_V    = 32'(SAT_TH);
    localparam logic [OUT_W-1:0] SAT_VAL_V   = OUT_W'(SAT_VAL);
    localparam logic [OUT_W-1:0] DEAD_FILL_V = OUT_W'(DEAD_FILL);
    localparam logic [OUT_W-1:0] TEST_BG_V   = OUT_W'(TEST_BG);
    localparam logic [OUT_W-1:0] MARK_MIN_V  = OUT_W'(MARK_MIN);
    localparam logic [OUT_W-1:0] MARK_MAX_V  = OUT_W'(MARK_MAX);
    localparam logic [OUT_W-1:0] MARK_STEP_V = OUT_W'(MARK_STEP);
    localparam logic [X_W-1:0]   MARK_X0_V   = X_W'(MARK_X0);
    localparam logic [X_W-1:0]   MARK_X1_V   = X_W'(MARK_X1);
    localparam logic [Y_W-1:0]   MARK_Y0_V   = Y_W'(MARK_Y0);
    localparam logic [Y_W-1:0]   MARK_Y1_V   = Y_W'(MARK_Y1);

    // stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0] s1_pix_q,   s1_pix_d;
    logic [X_W-1:0]   s1_x_q,     s1_x_d;
    logic [Y_W-1:0]   s1_y_q,     s1_y_d;
    logic             s1_dead_q,  s1_dead_d;

    // stage 2 / frame state registers
    logic             out_valid_q,    out_valid_d;
    logic [OUT_W-1:0] dout_q,         dout_d;
    logic [X_W-1:0]   out_x_q,        out_x_d;
    logic [Y_W-1:0]   out_y_q,        out_y_d;
    logic [OUT_W-1:0] last_good_q,    last_good_d;
    logic             test_active_q,  test_active_d;
    logic [OUT_W-1:0] marker_level_q, marker_level_d;

    logic [31:0]      din_ext;
    logic [OUT_W-1:0] prev_pix;
    logic             in_mark;

    assign din_ext = 32'(bus.din);

    // Stage 1: clamp overloaded samples, otherwise bit-select scale; hold payload across bubbles
    always_comb begin
        s1_valid_d = bus.in_valid;
        s1_pix_d   = s1_pix_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_dead_d  = s1_dead_q;
        if (bus.in_valid) begin
            s1_pix_d  = (din_ext >= SAT_TH_V) ? SAT_VAL_V : bus.din[OUT_W+SHIFT-1:SHIFT];
            s1_x_d    = bus.x;
            s1_y_d    = bus.y;
            s1_dead_d = bus.dead_pix;
        end
    end

    // Stage 1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_dead_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pix_q   <= s1_pix_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_dead_q  <= s1_dead_d;
        end
    end

    // Stage 2: dead fill, test pattern overlay, and frame-boundary mode/marker update.
    // Frame state is read as its old value here, so a frame_start only affects later pixels.
    always_comb begin
        out_valid_d    = s1_valid_q;
        dout_d         = dout_q;
        out_x_d        = out_x_q;
        out_y_d        = out_y_q;
        last_good_d    = last_good_q;
        test_active_d  = test_active_q;
        marker_level_d = marker_level_q;
        prev_pix       = (s1_x_q == '0) ? DEAD_FILL_V : last_good_q;
        in_mark        = (s1_x_q >= MARK_X0_V) && (s1_x_q <= MARK_X1_V)
                      && (s1_y_q >= MARK_Y0_V) && (s1_y_q <= MARK_Y1_V);
        if (s1_valid_q) begin
            out_x_d = s1_x_q;
            out_y_d = s1_y_q;
            if (s1_dead_q) begin
                dout_d = prev_pix;
            end else begin
                dout_d      = s1_pix_q;
                last_good_d = s1_pix_q;
            end
            if (test_active_q) begin
                dout_d = in_mark ? marker_level_q : TEST_BG_V;
            end
        end
        if (frame_start) begin
            test_active_d = test_req;
            if (test_active_q) begin
                marker_level_d = (marker_level_q >= MARK_MAX_V) ? MARK_MIN_V
                                                                : marker_level_q + MARK_STEP_V;
            end
        end
    end

    // Stage 2 and frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            dout_q         <= '0;
            out_x_q        <= '0;
            out_y_q        <= '0;
            last_good_q    <= DEAD_FILL_V;
            test_active_q  <= 1'b0;
            marker_level_q <= MARK_MIN_V;
        end else begin
            out_valid_q    <= out_valid_d;
            dout_q         <= dout_d;
            out_x_q        <= out_x_d;
            out_y_q        <= out_y_d;
            last_good_q    <= last_good_d;
            test_active_q  <= test_active_d;
            marker_level_q <= marker_level_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign test_active   = test_active_q;
    assign marker_level  = marker_level_q;

`ifdef DEAD_CNT_EN
    logic [15:0] dead_acc_q,   dead_acc_d;
    logic [15:0] dead_count_q, dead_count_d;
    logic [15:0] dead_acc_inc;

    // Per-frame dead pixel tally; the snapshot includes a dead pixel leaving stage 2 on the boundary cycle
    always_comb begin
        dead_acc_inc = dead_acc_q;
        if (s1_valid_q && s1_dead_q && (dead_acc_q != 16'hFFFF)) begin
            dead_acc_inc = dead_acc_q + 16'd1;
        end
        dead_acc_d   = dead_acc_inc;
        dead_count_d = dead_count_q;
        if (frame_start) begin
            dead_count_d = dead_acc_inc;
            dead_acc_d   = 16'd0;
        end
    end

    // Dead counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dead_acc_q   <= 16'd0;
            dead_count_q <= 16'd0;
        end else begin
            dead_acc_q   <= dead_acc_d;
            dead_count_q <= dead_count_d;
        end
    end

    assign dead_count = dead_count_q;
`endif

endmodule

// File: tb/tb_pixel_condition_pipe.sv
// tb/tb_pixel_condition_pipe.sv - directed self-checking bench for pixel_condition_pipe
module tb_pixel_condition_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       test_req;
    logic       test_active;
    logic [9:0] marker_level;
`ifdef DEAD_CNT_EN
    logic [15:0] dead_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pixel_condition_pipe_if bus_if ();

    pixel_condition_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .frame_start  (frame_start),
        .test_req     (test_req),
        .test_active  (test_active),
        .marker_level (marker_level)
`ifdef DEAD_CNT_EN
        ,
        .dead_count   (dead_count)
`endif
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [6:0] xx, input logic [5:0] yy, input logic dd);
        bus_if.in_valid = 1'b1;
        bus_if.din      = d;
        bus_if.x        = xx;
        bus_if.y        = yy;
        bus_if.dead_pix = dd;
    endtask

    task automatic idle();
        bus_if.in_valid = 1'b0;
        bus_if.dead_pix = 1'b0;
    endtask

    task automatic px_check(input string tag, input logic [15:0] d, input logic [6:0] xx,
                            input logic [5:0] yy, input logic dd, input logic [9:0] exp);
        drive(d, xx, yy, dd);
        tick();
        idle();
        tick();
        expect_eq({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
        expect_eq(tag, 32'(bus_if.dout), 32'(exp));
    endtask

    task automatic fs(input logic req);
        test_req    = req;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        frame_start  = 1'b0;
        test_req     = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.din      = '0;
        bus_if.x        = '0;
        bus_if.y        = '0;
        bus_if.dead_pix = 1'b0;
        tick();
        tick();
        expect_eq("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        expect_eq("rst_dout",      32'(bus_if.dout),      32'd0);
        expect_eq("rst_out_x",     32'(bus_if.out_x),     32'd0);
        expect_eq("rst_out_y",     32'(bus_if.out_y),     32'd0);
        expect_eq("rst_test_act",  32'(test_active),      32'd0);
        expect_eq("rst_marker",    32'(marker_level),     32'd250);
        rst = 1'b0;
        tick();

        // clamp and scaling
        px_check("clamp_2044", 16'd2044,  7'd5, 6'd1, 1'b0, 10'd1022);
        px_check("clamp_2045", 16'd2045,  7'd5, 6'd1, 1'b0, 10'd1022);
        px_check("clamp_ffff", 16'hFFFF,  7'd5, 6'd1, 1'b0, 10'd1022);
        px_check("clamp_2043", 16'd2043,  7'd5, 6'd1, 1'b0, 10'd1021);

        // dead-pixel run along a line
        px_check("dead_x0", 16'd200, 7'd0, 6'd2, 1'b0, 10'd100);
        px_check("dead_x1", 16'd400, 7'd1, 6'd2, 1'b0, 10'd200);
        px_check("dead_x2", 16'd999, 7'd2, 6'd2, 1'b1, 10'd200);
        px_check("dead_x3", 16'd777, 7'd3, 6'd2, 1'b1, 10'd200);
        px_check("dead_x4", 16'd600, 7'd4, 6'd2, 1'b0, 10'd300);
        px_check("dead_at0", 16'd50, 7'd0, 6'd3, 1'b1, 10'd512);

        // latency and bubbles: in 1,0,1,1,0,0 -> out 0,0,1,0,1,1
        tick();
        drive(16'd20, 7'd10, 6'd3, 1'b0);
        expect_eq("lat_c0", 32'(bus_if.out_valid), 32'd0);
        tick();
        idle();
        expect_eq("lat_c1", 32'(bus_if.out_valid), 32'd0);
        tick();
        drive(16'd24, 7'd12, 6'd3, 1'b0);
        expect_eq("lat_c2",      32'(bus_if.out_valid), 32'd1);
        expect_eq("lat_c2_x",    32'(bus_if.out_x),     32'd10);
        expect_eq("lat_c2_dout", 32'(bus_if.dout),      32'd10);
        tick();
        drive(16'd26, 7'd13, 6'd4, 1'b0);
        expect_eq("lat_c3", 32'(bus_if.out_valid), 32'd0);
        tick();
        idle();
        expect_eq("lat_c4",      32'(bus_if.out_valid), 32'd1);
        expect_eq("lat_c4_x",    32'(bus_if.out_x),     32'd12);
        expect_eq("lat_c4_dout", 32'(bus_if.dout),      32'd12);
        tick();
        expect_eq("lat_c5",      32'(bus_if.out_valid), 32'd1);
        expect_eq("lat_c5_x",    32'(bus_if.out_x),     32'd13);
        expect_eq("lat_c5_y",    32'(bus_if.out_y),     32'd4);
        expect_eq("lat_c5_dout", 32'(bus_if.dout),      32'd13);
        tick();

        // test pattern ramp
        fs(1'b1);
        expect_eq("ramp_act1",   32'(test_active),  32'd1);
        expect_eq("ramp_mark1",  32'(marker_level), 32'd250);
        for (int k = 2; k <= 16; k++) begin
            fs(1'b1);
            expect_eq($sformatf("ramp_mark%0d", k), 32'(marker_level), 32'(250 + 50 * (k - 1)));
        end
        px_check("pat_39_31", 16'd0,   7'd39, 6'd31, 1'b0, 10'd1000);
        px_check("pat_41_31", 16'd0,   7'd41, 6'd31, 1'b0, 10'd10);
        px_check("pat_40_32", 16'd300, 7'd40, 6'd32, 1'b1, 10'd1000);
        px_check("pat_39_33", 16'd0,   7'd39, 6'd33, 1'b0, 10'd10);
        fs(1'b1);
        expect_eq("ramp_wrap", 32'(marker_level), 32'd250);

        // frame_start with a marker pixel in stage 2
        drive(16'd0, 7'd39, 6'd31, 1'b0);
        tick();
        drive(16'd0, 7'd40, 6'd32, 1'b0);
        frame_start = 1'b1;
        tick();
        idle();
        frame_start = 1'b0;
        expect_eq("sim_old_dout", 32'(bus_if.dout),   32'd250);
        expect_eq("sim_old_x",    32'(bus_if.out_x),  32'd39);
        expect_eq("sim_marker",   32'(marker_level),  32'd300);
        tick();
        expect_eq("sim_new_dout", 32'(bus_if.dout),   32'd300);
        expect_eq("sim_new_x",    32'(bus_if.out_x),  32'd40);

        // leave test mode at the next boundary
        fs(1'b0);
        expect_eq("off_act",    32'(test_active),  32'd0);
        expect_eq("off_marker", 32'(marker_level), 32'd350);
        px_check("off_pix", 16'd1000, 7'd50, 6'd5, 1'b0, 10'd500);

        // reset with two pixels in flight
        drive(16'd400, 7'd1, 6'd1, 1'b0);
        tick();
        drive(16'd402, 7'd2, 6'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_eq("mid_rst_valid",  32'(bus_if.out_valid), 32'd0);
        expect_eq("mid_rst_marker", 32'(marker_level),     32'd250);
        expect_eq("mid_rst_dout",   32'(bus_if.dout),      32'd0);
        tick();
        idle();
        rst = 1'b0;
        tick();
        expect_eq("post_rst_v1", 32'(bus_if.out_valid), 32'd0);
        tick();
        expect_eq("post_rst_v2", 32'(bus_if.out_valid), 32'd0);

`ifdef DEAD_CNT_EN
        expect_eq("dc_reset", 32'(dead_count), 32'd0);
        drive(16'd10, 7'd1, 6'd0, 1'b1);
        tick();
        drive(16'd10, 7'd2, 6'd0, 1'b1);
        tick();
        drive(16'd10, 7'd3, 6'd0, 1'b1);
        tick();
        idle();
        tick();
        fs(1'b0);
        expect_eq("dc_three", 32'(dead_count), 32'd3);
        fs(1'b0);
        expect_eq("dc_restart", 32'(dead_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_condition_pipe.md
Name: pixel_condition_pipe

Overview:
Clocked, parametrised successor to the combinational pixel output conditioner. Sits between the frame-memory read port and the video output formatter. Per valid pixel it does three things in a fixed 2-cycle pipeline: overload clamp with bit-select scaling, dead-pixel replacement from the last good pixel in the line, and a frame-synchronous test pattern with a ramping marker.

Parameters:
IN_W, 16, input sample width
OUT_W, 10, output pixel width
SHIFT, 1, LSBs dropped when scaling: dout = din[OUT_W+SHIFT-1:SHIFT]
SAT_TH, 2045, input value at or above which the pixel is clamped
SAT_VAL, 1022, clamp output value
DEAD_FILL, 512, substitute for a dead pixel at x==0
X_W, 7, column coordinate width
Y_W, 6, row coordinate width
MARK_X0, 39 / MARK_X1, 40, marker column range, inclusive
MARK_Y0, 31 / MARK_Y1, 32, marker row range, inclusive
MARK_MIN, 250 / MARK_MAX, 1000 / MARK_STEP, 50, marker ramp
TEST_BG, 10, test-pattern background level

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  din/x/y/dead_pix qualify this cycle
din  in  IN_W  raw sample
x  in  X_W  column of din
y  in  Y_W  row of din
dead_pix  in  1  din is from a flagged dead pixel
frame_start  in  1  single-cycle pulse at frame boundary
test_req  in  1  test-pattern request (level)
out_valid  out  1  dout/out_x/out_y valid
dout  out  OUT_W  conditioned pixel
out_x  out  X_W  column of dout
out_y  out  Y_W  row of dout
test_active  out  1  test pattern currently applied
marker_level  out  OUT_W  current marker value

Behaviour:
- Width rule: OUT_W+SHIFT <= IN_W. SAT_VAL, DEAD_FILL and MARK_* must be < 2^OUT_W. Violations fail elaboration.
- Latency is fixed at 2 clocks. out_valid equals in_valid delayed 2 clocks. There is no backpressure. Bubbles pass through unchanged.
- Stage 1, on in_valid: s1 = SAT_VAL if din >= SAT_TH (unsigned compare), else din[OUT_W+SHIFT-1:SHIFT]. Register s1, x, y and dead_pix.
- Stage 2, dead replacement:
  - Register last_good (OUT_W bits, reset DEAD_FILL).
  - On a valid stage-1 pixel with x==0, the "previous" value is DEAD_FILL; otherwise it is last_good.
  - If dead, the output is the previous value. If not dead, the output is s1 and last_good is loaded with s1.
  - Dead pixels never update last_good. Consecutive dead pixels all take the same last good value.
- Test pattern:
  - test_active is loaded from test_req only on a cycle where frame_start=1, so mode changes only at a frame boundary.
  - marker_level: on frame_start with test_active=1 (old value), if marker_level >= MARK_MAX it becomes MARK_MIN, else marker_level+MARK_STEP. It holds otherwise.
  - While test_active: dout = marker_level if MARK_X0<=x<=MARK_X1 and MARK_Y0<=y<=MARK_Y1 (stage-2 coordinates), else TEST_BG. Dead replacement and the last_good update still run.
- Simultaneous events: frame_start coinciding with a pixel in stage 2 takes effect from the following cycle. That pixel uses the old test_active and marker_level.
- Reset: dout=0, out_x=0, out_y=0, out_valid=0, test_active=0, marker_level=MARK_MIN, last_good=DEAD_FILL. Pipeline valids clear. Reset asserted mid-line discards in-flight pixels with no spurious out_valid.

Optional Feature:
Macro DEAD_CNT_EN.
- Defined:
  - Adds output dead_count (16 bits) and an internal 16-bit accumulator.
  - The accumulator increments per valid dead pixel in stage 2 and saturates at 0xFFFF.
  - On frame_start, dead_count loads the accumulator value including any dead pixel in stage 2 that cycle. The accumulator then restarts at 0.
  - Reset clears both.
- Undefined: port and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Clamp: din=2044, 2045 and 0xFFFF, valid, test off -> dout=1022, 1022, 1022 two cycles later. din=2043 -> dout=1021.
- Dead run: x=0..4, din=200,400,dead,dead,600 -> dout=100,200,200,200,300. Dead at x=0 -> dout=512.
- Latency/bubbles: in_valid pattern 1,0,1,1 -> out_valid pattern 0,0,1,0,1,1. out_x/out_y track their pixels.
- Test ramp: test_req=1, then 17 frame_start pulses. test_active rises after the 1st pulse. marker_level goes 250,300,...,1000 (after 16 pulses), then 250 on the 17th. Pixel (39,31) -> marker_level, (41,31) -> 10.
- Simultaneous: frame_start in the same cycle a marker pixel is in stage 2 -> that pixel shows the old marker_level, the next shows the new one.
- Reset mid-line: assert rst with 2 pixels in flight -> out_valid=0 immediately, marker_level=250. With DEAD_CNT_EN: 3 dead pixels, then frame_start -> dead_count=3.
